// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions used by the register fabric and its masters.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } bridge_state_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master. Turns one command into one AXI-Lite
// read or write, returns the slave's response on a simple valid/ready port,
// and raises a sticky flag when a transaction stalls for too long.
module axi_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              axi_clk,
    input  logic              axi_resetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              timeout_err,

    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [STRB_W-1:0] axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready
);

    // Counter is wide enough to hold TIMEOUT itself so it can saturate there.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    bridge_state_t   state;
    bridge_state_t   state_next;
    logic            cmd_ready_next;
    logic            awvalid_next;
    logic            wvalid_next;
    logic            bready_next;
    logic            arvalid_next;
    logic            rready_next;
    logic            rsp_valid_next;
    logic            cmd_accept;
    logic            busy;
    logic [WD_W-1:0] wd_count;

    assign cmd_accept = (state == IDLE) && cmd_valid && cmd_ready;
    assign busy       = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                        (state == RD_ADDR) || (state == RD_DATA);

    // Next-state and next-output decode; every handshake output is registered.
    always_comb begin
        state_next     = state;
        awvalid_next   = axi_awvalid;
        wvalid_next    = axi_wvalid;
        bready_next    = axi_bready;
        arvalid_next   = axi_arvalid;
        rready_next    = axi_rready;
        rsp_valid_next = rsp_valid;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_write) begin
                        state_next   = WR_ADDR_DATA;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        state_next   = RD_ADDR;
                        arvalid_next = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // A channel whose valid is already low has finished its handshake.
                if (axi_awvalid && axi_awready) awvalid_next = 1'b0;
                if (axi_wvalid && axi_wready)   wvalid_next  = 1'b0;
                if (!axi_awvalid && !axi_wvalid) begin
                    state_next  = WR_RESP;
                    bready_next = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi_bvalid && axi_bready) begin
                    state_next  = RSP;
                    bready_next = 1'b0;
                end
            end
            RD_ADDR: begin
                if (axi_arvalid && axi_arready) begin
                    state_next   = RD_DATA;
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                end
            end
            RD_DATA: begin
                if (axi_rvalid && axi_rready) begin
                    state_next  = RSP;
                    rready_next = 1'b0;
                end
            end
            RSP: begin
                // First RSP cycle presents the captured payload, then valid rises.
                if (!rsp_valid) begin
                    rsp_valid_next = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        cmd_ready_next = (state_next == IDLE);
    end

    // State and handshake output registers; reset drops every valid at once.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_ready   <= cmd_ready_next;
            axi_awvalid <= awvalid_next;
            axi_wvalid  <= wvalid_next;
            axi_bready  <= bready_next;
            axi_arvalid <= arvalid_next;
            axi_rready  <= rready_next;
            rsp_valid   <= rsp_valid_next;
        end
    end

    // Command payload capture on accept and response capture on B/R handshake.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            axi_awaddr <= '0;
            axi_araddr <= '0;
            axi_wdata  <= '0;
            axi_wstrb  <= '0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= OKAY;
        end else begin
            if (cmd_accept) begin
                rsp_write <= cmd_write;
                if (cmd_write) begin
                    axi_awaddr <= cmd_addr;
                    axi_wdata  <= cmd_wdata;
                    axi_wstrb  <= cmd_wstrb;
                end else begin
                    axi_araddr <= cmd_addr;
                end
            end
            if ((state == WR_RESP) && axi_bvalid && axi_bready) begin
                rsp_rdata <= '0;
                rsp_resp  <= axi_bresp;
            end
            if ((state == RD_DATA) && axi_rvalid && axi_rready) begin
                rsp_rdata <= axi_rdata;
                rsp_resp  <= axi_rresp;
            end
        end
    end

    // Watchdog: saturating cycle count while the AXI side is open; flag is sticky.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wd_count    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (cmd_accept) begin
                wd_count <= '0;
            end else if (busy && (wd_count != WD_MAX)) begin
                wd_count <= wd_count + WD_W'(1);
            end
            if ((TIMEOUT != 0) && busy && (wd_count == WD_LAST)) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a hand-driven AXI-Lite slave.
module tb_axi_lite_master_bridge;
    import axi_lite_pkg::*;

    localparam int ADDR_W = 32;

    logic              axi_clk = 1'b0;
    logic              axi_resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic [3:0]        cmd_wstrb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              timeout_err;
    logic [ADDR_W-1:0] axi_awaddr;
    logic              axi_awvalid;
    logic              axi_awready = 1'b0;
    logic [31:0]       axi_wdata;
    logic [3:0]        axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready = 1'b0;
    logic [1:0]        axi_bresp = 2'b00;
    logic              axi_bvalid = 1'b0;
    logic              axi_bready;
    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_arvalid;
    logic              axi_arready = 1'b0;
    logic [31:0]       axi_rdata = '0;
    logic [1:0]        axi_rresp = 2'b00;
    logic              axi_rvalid = 1'b0;
    logic              axi_rready;

    int assert_count = 0;
    int fail_count   = 0;
    int aw_hs = 0;
    int w_hs  = 0;
    int b_hs  = 0;
    int aw_base, w_base, b_base;

    axi_lite_master_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 axi_clk = ~axi_clk;

    // Handshake counters seen by the slave side.
    always @(posedge axi_clk) begin
        if (axi_awvalid && axi_awready) aw_hs++;
        if (axi_wvalid && axi_wready)   w_hs++;
        if (axi_bvalid && axi_bready)   b_hs++;
    end

    // Hard stop in case something wedges the initial block.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: sim time exceeded");
        $fatal(1, "[TB] bench stalled");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Offers one command and returns just after the accepting clock edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        int n;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_wait", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic retire(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({tag, "_rsp_drop"}, rsp_valid, 1'b0);
        checkOutput({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        // Reset values
        #12;
        checkOutput("rst_cmd_ready", cmd_ready, 1'b0);
        checkOutput("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, rsp_valid}, 4'b0);
        checkOutput("rst_readies", {axi_bready, axi_rready}, 2'b0);
        checkOutput("rst_addrs", {axi_awaddr, axi_araddr}, 64'h0);
        checkOutput("rst_data", {axi_wdata, rsp_rdata}, 64'h0);
        checkOutput("rst_misc", {axi_wstrb, rsp_resp, rsp_write, timeout_err}, 8'h0);
        @(posedge axi_clk);
        #1 axi_resetn = 1'b1;
        tick();
        checkOutput("idle_cmd_ready", cmd_ready, 1'b1);

        // Write 0x10 <= 0xDEADBEEF with a zero-wait slave
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        aw_base = aw_hs; w_base = w_hs; b_base = b_hs;
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        checkOutput("wr_valids", {axi_awvalid, axi_wvalid}, 2'b11);
        checkOutput("wr_awaddr", axi_awaddr, 32'h0000_0010);
        checkOutput("wr_wdata", axi_wdata, 32'hDEAD_BEEF);
        checkOutput("wr_wstrb", axi_wstrb, 4'hF);
        checkOutput("wr_cmd_ready", cmd_ready, 1'b0);
        tick();
        checkOutput("wr_valids_drop", {axi_awvalid, axi_wvalid}, 2'b00);
        axi_bvalid = 1'b1;
        axi_bresp  = OKAY;
        tick();
        checkOutput("wr_bready", axi_bready, 1'b1);
        tick();
        axi_bvalid = 1'b0;
        checkOutput("wr_bready_drop", axi_bready, 1'b0);
        checkOutput("wr_rsp_early", rsp_valid, 1'b0);
        tick();
        checkOutput("wr_rsp_valid_c4", rsp_valid, 1'b1);
        checkOutput("wr_rsp_resp", rsp_resp, OKAY);
        checkOutput("wr_rsp_write", rsp_write, 1'b1);
        checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("wr_hs_counts", {8'(aw_hs - aw_base), 8'(w_hs - w_base), 8'(b_hs - b_base)}, 24'h010101);
        retire("wr");

        // Read 0x10, slave returns 0xDEADBEEF
        axi_arready = 1'b1;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        checkOutput("rd_arvalid", axi_arvalid, 1'b1);
        checkOutput("rd_araddr", axi_araddr, 32'h0000_0010);
        tick();
        checkOutput("rd_ar_drop_rready", {axi_arvalid, axi_rready}, 2'b01);
        axi_rvalid = 1'b1;
        axi_rdata  = 32'hDEAD_BEEF;
        axi_rresp  = OKAY;
        tick();
        axi_rvalid = 1'b0;
        checkOutput("rd_rsp_early", rsp_valid, 1'b0);
        checkOutput("rd_rready_drop", axi_rready, 1'b0);
        tick();
        checkOutput("rd_rsp_valid_c3", rsp_valid, 1'b1);
        checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_rsp_resp", rsp_resp, OKAY);
        checkOutput("rd_rsp_write", rsp_write, 1'b0);
        retire("rd");

        // W handshake three cycles ahead of AW
        axi_awready = 1'b0;
        axi_wready  = 1'b1;
        aw_base = aw_hs; w_base = w_hs; b_base = b_hs;
        applyStimulus(1'b1, 32'h0000_0024, 32'h0BAD_F00D, 4'h3);
        checkOutput("ooo_valids", {axi_awvalid, axi_wvalid}, 2'b11);
        tick();
        checkOutput("ooo_w_drop", {axi_awvalid, axi_wvalid}, 2'b10);
        tick();
        checkOutput("ooo_aw_hold1", {axi_awvalid, axi_wvalid}, 2'b10);
        tick();
        checkOutput("ooo_aw_hold2", {axi_awvalid, axi_awaddr}, {1'b1, 32'h0000_0024});
        axi_awready = 1'b1;
        tick();
        axi_awready = 1'b0;
        checkOutput("ooo_aw_drop", axi_awvalid, 1'b0);
        axi_bvalid = 1'b1;
        axi_bresp  = DECERR;
        tick();
        checkOutput("ooo_bready", axi_bready, 1'b1);
        tick();
        axi_bvalid = 1'b0;
        tick();
        checkOutput("ooo_rsp_valid", rsp_valid, 1'b1);
        checkOutput("ooo_rsp_resp", rsp_resp, DECERR);
        checkOutput("ooo_hs_counts", {8'(aw_hs - aw_base), 8'(w_hs - w_base), 8'(b_hs - b_base)}, 24'h010101);
        checkOutput("ooo_no_timeout", timeout_err, 1'b0);
        retire("ooo");

        // SLVERR read with a consumer that stalls for five cycles
        axi_arready = 1'b1;
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        tick();
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h1234_5678;
        axi_rresp  = SLVERR;
        tick();
        axi_rvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold_valid_%0d", i), rsp_valid, 1'b1);
            checkOutput($sformatf("hold_resp_%0d", i), rsp_resp, SLVERR);
            checkOutput($sformatf("hold_rdata_%0d", i), rsp_rdata, 32'h1234_5678);
            checkOutput($sformatf("hold_cmd_ready_%0d", i), cmd_ready, 1'b0);
            tick();
        end
        retire("hold");

        // Watchdog: B withheld until cycle 20 after accept
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        applyStimulus(1'b1, 32'h0000_0080, 32'hCAFE_0001, 4'hF);
        for (int i = 1; i <= 7; i++) tick();
        checkOutput("wd_clear_c7", timeout_err, 1'b0);
        tick();
        checkOutput("wd_set_c8", timeout_err, 1'b1);
        for (int i = 9; i <= 20; i++) tick();
        checkOutput("wd_still_waiting", {axi_bready, rsp_valid}, 2'b10);
        axi_bvalid = 1'b1;
        axi_bresp  = OKAY;
        tick();
        axi_bvalid = 1'b0;
        checkOutput("wd_rsp_early", rsp_valid, 1'b0);
        tick();
        checkOutput("wd_rsp_valid", rsp_valid, 1'b1);
        checkOutput("wd_rsp_resp", rsp_resp, OKAY);
        retire("wd");
        checkOutput("wd_sticky", timeout_err, 1'b1);

        // Reset pulse while arvalid is high
        axi_arready = 1'b0;
        applyStimulus(1'b0, 32'h0000_00C0, 32'h0, 4'h0);
        tick();
        checkOutput("rst_mid_arvalid_before", axi_arvalid, 1'b1);
        #2 axi_resetn = 1'b0;
        #1;
        checkOutput("rst_mid_arvalid_async", axi_arvalid, 1'b0);
        checkOutput("rst_mid_timeout_clr", timeout_err, 1'b0);
        checkOutput("rst_mid_cmd_ready", cmd_ready, 1'b0);
        @(posedge axi_clk);
        #1 axi_resetn = 1'b1;
        tick();
        checkOutput("rst_mid_idle_ready", cmd_ready, 1'b1);
        axi_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst_mid_quiet_%0d", i), {axi_arvalid, rsp_valid}, 2'b00);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
